// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_1bit.sv
// Single-bit full subtractor: d = a - b - bi, with the borrow passed on to the next stage.
import serial_subtractor_pkg::*;

module subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB-first, using a single full-subtractor stage.
import serial_subtractor_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic             borrow_q;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             bo_bit;
    logic             load;
    logic             last;

    subtractor_1bit u_fullsub (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (borrow_q),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // d_sh collects the lower WIDTH-1 result bits; the final bit joins them only when the
    // result is published, so diff never shows partial shift contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            borrow_q   <= 1'b0;
            count      <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                a_sh     <= a;
                b_sh     <= b;
                a_msb    <= a[WIDTH-1];
                b_msb    <= b[WIDTH-1];
                borrow_q <= 1'b0;
                count    <= '0;
            end else if (state == S_RUN) begin
                a_sh     <= a_sh >> 1;
                b_sh     <= b_sh >> 1;
                d_sh     <= (WIDTH-1)'({d_bit, d_sh} >> 1);
                borrow_q <= bo_bit;
                count    <= count + CW'(1);
            end
            if (last) begin
                diff       <= {d_bit, d_sh};
                borrow_out <= bo_bit;
                overflow   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed corner cases plus random ops vs an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W-1:0] held_diff;
    logic         held_borrow;
    logic         held_ov;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_diff"},   32'(diff),       32'(held_diff));
        checkOutput({tag, "_borrow"}, 32'(borrow_out), 32'(held_borrow));
        checkOutput({tag, "_ovf"},    32'(overflow),   32'(held_ov));
    endtask

    task automatic idleCycle();
        step();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkHeld("idle");
    endtask

    // One complete operation from the accepting edge through the done cycle; returns inside the done cycle.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input bit hold_start, input bit noisy, input int glitch);
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ov;
        int           res;
        res        = int'($signed(op_a)) - int'($signed(op_b));
        exp_diff   = op_a - op_b;
        exp_borrow = (op_a < op_b);
        exp_ov     = (res > 127) || (res < -128);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        step();
        for (int k = 0; k < W; k++) begin
            checkOutput("run_busy", 32'(busy), 32'd1);
            checkOutput("run_done", 32'(done), 32'd0);
            checkHeld("run_hold");
            if (hold_start) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else if (k == glitch) begin
                start = 1'b1;
                a     = W'(1);
                b     = W'(1);
            end else if (noisy) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        checkOutput("done_pulse", 32'(done),       32'd1);
        checkOutput("done_busy",  32'(busy),       32'd0);
        checkOutput("diff",       32'(diff),       32'(exp_diff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(exp_borrow));
        checkOutput("overflow",   32'(overflow),   32'(exp_ov));
        held_diff   = exp_diff;
        held_borrow = exp_borrow;
        held_ov     = exp_ov;
        if (!hold_start) start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        held_diff   = '0;
        held_borrow = 1'b0;
        held_ov     = 1'b0;
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkHeld("rst");
        rst = 1'b0;
        idleCycle();

        $display("[TB] directed corner cases");
        applyStimulus(8'd200, 8'd55, 1'b0, 1'b0, -1);
        idleCycle();
        applyStimulus(8'd5, 8'd9, 1'b0, 1'b0, -1);
        idleCycle();
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, -1);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0, -1);
        idleCycle();
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b0, -1);
        idleCycle();

        $display("[TB] start pulse while busy is ignored");
        applyStimulus(8'd10, 8'd3, 1'b0, 1'b0, 3);
        idleCycle();

        $display("[TB] reset in the middle of an operation");
        a     = 8'd100;
        b     = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("rstmid_busy", 32'(busy), 32'd1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        held_diff   = '0;
        held_borrow = 1'b0;
        held_ov     = 1'b0;
        checkOutput("rstmid_busy0", 32'(busy), 32'd0);
        checkOutput("rstmid_done0", 32'(done), 32'd0);
        checkHeld("rstmid");
        for (int i = 0; i < 12; i++) idleCycle();
        applyStimulus(8'd3, 8'd2, 1'b0, 1'b0, -1);
        idleCycle();

        $display("[TB] back-to-back with start held high");
        for (int i = 0; i < 6; i++) applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b0, -1);
        start = 1'b0;
        idleCycle();

        $display("[TB] random operations with noisy inputs during RUN");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b1, -1);
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
